hex_scroller: RTL
=================

HEX_SCROLLER -- requirements
Module: hex_scroller

Interface
REQ-001 The block SHALL use one clock, CLOCK_50, and one synchronous, active-low reset, resetn; no other clocks or asynchronous logic.
REQ-002 Parameter NUM_DIGITS, 6: number of 7-segment digits driven (>=1).
REQ-003 Parameter MSG_LEN, 8: message buffer depth in characters (>=NUM_DIGITS).
REQ-004 Parameter TICK_DIV, 50000000: CLOCK_50 cycles per scroll step (>=1).
REQ-005 CLOCK_50  input  1  system clock, rising edge.
REQ-006 resetn  input  1  synchronous active-low reset.
REQ-007 code_in  input  2  character code: 00='d', 01='E', 10='1', 11=blank.
REQ-008 load  input  1  write code_in into buffer; sampled each cycle, level-qualified (one write per high cycle).
REQ-009 run  input  1  1=scroll, 0=idle.
REQ-010 hold  input  1  1=pause scrolling while run=1.
REQ-011 dir  input  1  0=scroll left (offset+1), 1=scroll right (offset-1).
REQ-012 HEX  output  7*NUM_DIGITS  active-low segments; digit i at HEX[7i+6:7i], bit0=seg a ... bit6=seg g; digit 0 rightmost.
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 step  output  1  one-cycle pulse on every cycle offset advances.

Function
REQ-015 Buffer: MSG_LEN x 2-bit registers; write pointer wr_ptr (0..MSG_LEN-1); scroll offset (0..MSG_LEN-1); prescaler (0..TICK_DIV-1).
REQ-016 FSM states IDLE, SCROLL, PAUSE; transitions evaluated each edge, run=0 has priority over hold.
REQ-017 IDLE->SCROLL when run=1 & hold=0; IDLE->PAUSE when run=1 & hold=1; SCROLL->PAUSE when hold=1; PAUSE->SCROLL when hold=0; SCROLL/PAUSE->IDLE when run=0.
REQ-018 Entering IDLE SHALL clear offset and prescaler to 0 on the same edge; buffer and wr_ptr retained.
REQ-019 load=1 in IDLE: buffer[wr_ptr]<=code_in, wr_ptr<=wr_ptr+1, MSG_LEN-1 wraps to 0 (oldest overwritten, no full flag).
REQ-020 load SHALL be ignored in SCROLL and PAUSE; load and run both high in IDLE: write performed and FSM leaves IDLE on the same edge.
REQ-021 Prescaler increments each SCROLL cycle; at TICK_DIV-1 it wraps to 0 and a step occurs; frozen (value retained) in PAUSE.
REQ-022 On step: dir=0 offset<=offset+1 (MSG_LEN-1 wraps to 0); dir=1 offset<=offset-1 (0 wraps to MSG_LEN-1); step asserted that cycle.
REQ-023 TICK_DIV=1: a step SHALL occur on every SCROLL cycle.
REQ-024 Digit i SHALL display buffer[(offset+NUM_DIGITS-1-i) mod MSG_LEN]; leftmost digit shows buffer[offset].
REQ-025 Glyphs (active-low, g..a): 'd'=0100001, 'E'=0000110, '1'=1111001, blank=1111111.
REQ-026 HEX SHALL be registered: reflects buffer/offset one cycle after they change.

Reset
REQ-027 resetn=0 at an edge SHALL force: state IDLE, all buffer entries 11 (blank), wr_ptr 0, offset 0, prescaler 0, step 0, busy 0, HEX all ones; takes priority over load/run/hold, including mid-scroll.

Verification (NUM_DIGITS=3, MSG_LEN=4, TICK_DIV=4)
REQ-028 Reset: resetn low 2 cycles -> HEX=21'h1FFFFF, busy=0, step=0.
REQ-029 Load d,E,1 on three IDLE cycles -> HEX2=0100001, HEX1=0000110, HEX0=1111001; fourth and fifth loads of 'E','d' -> buffer[3]='E', wrap overwrites buffer[0]='d'.
REQ-030 After loading d,E,1, run=1, dir=0 -> busy next edge, step every 4 cycles; after first step HEX2..0 = E,1,blank; after 4 steps back to d,E,1; load pulses during scroll change nothing.
REQ-031 From offset 0, dir=1 -> first step offset 3, HEX2..0 = blank,d,E.
REQ-032 hold=1 with prescaler at 2 for 10 cycles -> no step, busy=1; hold=0 -> step exactly 2 SCROLL cycles later.
REQ-033 run=0 mid-scroll at offset 2 -> IDLE, offset 0, display d,E,1 one cycle later; repeat with resetn=0 instead -> all-blank display, buffer cleared.

Source files
------------

// File: rtl/hex_scroller.sv
// Scrolling 7-segment message display: a small character buffer loaded while idle,
// shown through a NUM_DIGITS-wide window that slides by one position every TICK_DIV cycles.
module hex_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [1:0]              code_in,
  input  logic                    load,
  input  logic                    run,
  input  logic                    hold,
  input  logic                    dir,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic                    busy,
  output logic                    step
);

  localparam int OW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [OW-1:0] OFF_MAX = OW'(MSG_LEN - 1);
  localparam logic [PW-1:0] PS_MAX  = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SCROLL, PAUSE} state_t;

  state_t                  state;
  logic [1:0]              buffer [MSG_LEN];
  logic [OW-1:0]           wr_ptr;
  logic [OW-1:0]           offset;
  logic [PW-1:0]           prescaler;
  logic                    step_p1;
  logic [7*NUM_DIGITS-1:0] hex_p0;
  logic [7*NUM_DIGITS-1:0] hex_p1;

  function automatic logic [6:0] glyph(input logic [1:0] code);
    case (code)
      2'b00:   return 7'b0100001;
      2'b01:   return 7'b0000110;
      2'b10:   return 7'b1111001;
      default: return 7'b1111111;
    endcase
  endfunction

  // Circular +/-1 over 0..MSG_LEN-1; also used to advance the write pointer.
  function automatic logic [OW-1:0] offset_next(input logic [OW-1:0] cur, input logic d);
    if (!d)
      return (cur == OFF_MAX) ? '0 : cur + 1'b1;
    return (cur == '0) ? OFF_MAX : cur - 1'b1;
  endfunction

  function automatic logic [OW-1:0] digit_src(input logic [OW-1:0] off, input int i);
    int s;
    s = (int'(off) + NUM_DIGITS - 1 - i) % MSG_LEN;
    return OW'(s);
  endfunction

  // Stage p0: window decode from the current buffer and offset
  always_comb begin
    hex_p0 = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      hex_p0[7*i +: 7] = glyph(buffer[digit_src(offset, i)]);
  end

  // Stage p1: control FSM, buffer writes and registered display
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= IDLE;
      for (int k = 0; k < MSG_LEN; k++)
        buffer[k] <= 2'b11;
      wr_ptr    <= '0;
      offset    <= '0;
      prescaler <= '0;
      step_p1   <= 1'b0;
      hex_p1    <= '1;
    end else begin
      step_p1 <= 1'b0;
      hex_p1  <= hex_p0;
      case (state)
        IDLE: begin
          if (load) begin
            buffer[wr_ptr] <= code_in;
            wr_ptr         <= offset_next(wr_ptr, 1'b0);
          end
          if (run)
            state <= hold ? PAUSE : SCROLL;
        end
        SCROLL: begin
          if (!run) begin
            state     <= IDLE;
            offset    <= '0;
            prescaler <= '0;
          end else if (hold) begin
            state <= PAUSE;
          end else if (prescaler == PS_MAX) begin
            prescaler <= '0;
            offset    <= offset_next(offset, dir);
            step_p1   <= 1'b1;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        PAUSE: begin
          if (!run) begin
            state     <= IDLE;
            offset    <= '0;
            prescaler <= '0;
          end else if (!hold) begin
            state <= SCROLL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HEX  = hex_p1;
  assign step = step_p1;
  assign busy = (state != IDLE);

endmodule
